enc_scan: RTL
=============

# enc_scan

Parametrised, registered priority encoder with a valid/ready handshake on both sides. It accepts an N-bit request vector and emits the binary index of every set bit, one index per beat, in a configurable priority order. It replaces fixed-width one-hot encoders wherever the request vector may carry several set bits and every one must be serviced. It sits between request-collection logic (interrupt lines, button or sensor flags) and a downstream consumer that takes one index at a time.

## Interface
Parameters:
- N, 4, request vector width; legal range 2..256.
- MSB_FIRST, 0, 0: lowest set bit is emitted first; 1: highest set bit is emitted first.
- INV_IDX, 0, 1: emitted index is N-1-i instead of i (legacy encoder mapping).
- Local W = $clog2(N), index width.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request vector valid.
- req_vec  in  N  request vector; any number of bits may be set.
- req_ready  out  1  block can accept a vector.
- idx_valid  out  1  idx, idx_last and idx_zero are valid.
- idx  out  W  encoded index of the current bit.
- idx_last  out  1  current beat is the final beat for this vector.
- idx_zero  out  1  beat reports an all-zero vector (see Configuration).
- idx_ready  in  1  consumer accepts the beat.

## Operation
- Two states, IDLE and EMIT. An internal N-bit register `pend` holds the bits still to be serviced.
- IDLE: req_ready=1 and idx_valid=0. When req_valid is high, the block accepts: pend<=req_vec.
  - If req_vec≠0, go to EMIT. Compute idx and idx_last from req_vec and register them in the same edge.
  - If req_vec=0, behaviour depends on ENC_SCAN_ZERO_FLAG_EN.
- EMIT: req_ready=0 and idx_valid=1. idx points at the selected bit, which is the lowest set bit of pend (MSB_FIRST=0) or the highest (MSB_FIRST=1).
  - idx_last=1 when pend has exactly one set bit.
- Handshake: a beat completes when idx_valid and idx_ready are both high. On completion, clear the selected bit in pend.
  - If idx_last=1, go to IDLE.
  - Otherwise register the next idx and idx_last on the same edge.
- Stall: while idx_ready=0, idx, idx_last, idx_zero and pend hold stable.
- A req_vec change while in EMIT is ignored, because req_ready=0.
- Index arithmetic: idx is an unsigned W-bit value. With INV_IDX=1, idx = N-1-i computed in W bits. When N is not a power of two, the unused codes never appear.
- All outputs are registered. There is no combinational path from any input to any output.

## Timing
- Reset values: state=IDLE, req_ready=1, idx_valid=0, idx=0, idx_last=0, idx_zero=0, pend=0.
- Reset asserted mid-EMIT discards pend immediately, asynchronously. No further beats are emitted.
- Latency: vector accepted at edge t gives first idx_valid=1 after edge t (cycle t+1).
- Throughput: one index per cycle in EMIT while idx_ready=1. A K-bit vector drains in K cycles.
- Turnaround: a last-beat handshake at edge t raises req_ready in cycle t+1. The next vector can be accepted at edge t+1, and its first beat appears in cycle t+2.
- Minimum gap between vectors is therefore one idle cycle.

## Configuration
- Macro ENC_SCAN_ZERO_FLAG_EN.
- Defined: an accepted all-zero vector enters EMIT and emits exactly one beat with idx=0, idx_last=1, idx_zero=1.
  - The block returns to IDLE on that beat's handshake.
  - idx_zero=0 on every other beat.
- Not defined: an accepted all-zero vector is dropped. The block stays in IDLE, req_ready stays 1, and idx_zero is held at 0.

## Test plan
- N=4, MSB_FIRST=0, INV_IDX=0, idx_ready=1. Stimulus: req_vec=4'b1011. Required: idx 0,1,3 in three consecutive cycles, with idx_last=1 only on idx 3. req_ready returns to 1 in the cycle after the last beat.
- Backpressure, same config. Stimulus: req_vec=4'b0110 with idx_ready held low for 3 cycles. Required: idx=1 holds stable with idx_valid=1 for those 3 cycles; after release, idx=2 follows with idx_last=1.
- N=4, MSB_FIRST=1, INV_IDX=1. Stimulus: req_vec=4'b0001. Required: a single beat with idx=3 and idx_last=1. Stimulus: req_vec=4'b1000. Required: idx=0.
- N=8, MSB_FIRST=1. Stimulus: req_vec=8'hFF. Required: idx 7..0 over 8 cycles, with idx_last on idx 0. A req_vec change mid-drain has no effect.
- Zero vector. With the macro defined: one beat with idx_zero=1, idx=0, idx_last=1. Without the macro: no idx_valid pulse and req_ready stays 1.
- Reset. Stimulus: rst_n low for one cycle after the second beat of req_vec=4'b1111. Required: all outputs reach their reset values without waiting for a clock edge. The next vector 4'b0100 yields a single beat with idx=2.

Source files
------------

// File: rtl/enc_scan.sv
// enc_scan: registered priority encoder that streams the index of every set bit of an accepted vector.
// Optional macro ENC_SCAN_ZERO_FLAG_EN: an all-zero vector yields one beat flagged by idx_zero.
//
// state | meaning
// IDLE  | waiting for a request vector, req_ready high
// EMIT  | presenting one index per beat from pend, idx_valid high
module enc_scan #(
  parameter int N         = 4,
  parameter bit MSB_FIRST = 1'b0,
  parameter bit INV_IDX   = 1'b0,
  localparam int W        = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid,
  input  logic [N-1:0] req_vec,
  output logic         req_ready,
  output logic         idx_valid,
  output logic [W-1:0] idx,
  output logic         idx_last,
  output logic         idx_zero,
  input  logic         idx_ready
);

  typedef enum logic [0:0] {IDLE = 1'b0, EMIT = 1'b1} state_t;

  localparam logic [N-1:0] ONE = N'(1);

  state_t       state, state_nxt;
  logic [N-1:0] pend, pend_nxt, pend_clr;
  logic [W-1:0] idx_nxt, sel;
  logic         last_nxt, zero_nxt;

  // Later loop iterations overwrite earlier ones, so scan direction decides priority.
  function automatic logic [W-1:0] pick(input logic [N-1:0] v);
    logic [W-1:0] p;
    p = '0;
    for (int b = 0; b < N; b++) begin
      if (MSB_FIRST) begin
        if (v[b]) p = W'(b);
      end else if (v[N-1-b]) begin
        p = W'(N-1-b);
      end
    end
    return p;
  endfunction

  function automatic logic [W-1:0] map(input logic [W-1:0] p);
    return INV_IDX ? (W'(N-1) - p) : p;
  endfunction

  function automatic logic single(input logic [N-1:0] v);
    return (v != '0) && ((v & (v - ONE)) == '0);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pend     <= '0;
      idx      <= '0;
      idx_last <= 1'b0;
      idx_zero <= 1'b0;
    end else begin
      state    <= state_nxt;
      pend     <= pend_nxt;
      idx      <= idx_nxt;
      idx_last <= last_nxt;
      idx_zero <= zero_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pend_nxt  = pend;
    idx_nxt   = idx;
    last_nxt  = idx_last;
    zero_nxt  = idx_zero;
    sel       = pick(pend);
    pend_clr  = pend & ~(ONE << sel);
    case (state)
      IDLE: begin
        if (req_valid) begin
          pend_nxt = req_vec;
          if (req_vec != '0) begin
            state_nxt = EMIT;
            idx_nxt   = map(pick(req_vec));
            last_nxt  = single(req_vec);
            zero_nxt  = 1'b0;
          end
`ifdef ENC_SCAN_ZERO_FLAG_EN
          else begin
            state_nxt = EMIT;
            idx_nxt   = '0;
            last_nxt  = 1'b1;
            zero_nxt  = 1'b1;
          end
`endif
        end
      end
      EMIT: begin
        if (idx_ready) begin
          pend_nxt = pend_clr;
          if (idx_last) begin
            state_nxt = IDLE;
            last_nxt  = 1'b0;
            zero_nxt  = 1'b0;
          end else begin
            idx_nxt  = map(pick(pend_clr));
            last_nxt = single(pend_clr);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Both handshake flags decode straight from the state flop, so no input reaches them.
  assign req_ready = (state == IDLE);
  assign idx_valid = (state == EMIT);

endmodule
